clk_ratio_detector: RTL and testbench

- Receive-side counterpart of the clock divider. Takes one divided-clock/tick stream (÷2, ÷3, ÷4 or ÷8, each high for one clk per period) in the same clock domain.
- Measures the stream's period in clk cycles and decodes it back to the divider's 2-bit select code.
- Declares lock after a run of identical periods and flags loss of lock.
- Used to self-check the divider and to let downstream logic follow the active divide ratio.

---
 rtl/clk_ratio_detector.sv | 175 +++++++++++++++++
 tb/tb_clk_ratio_detector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_detector.sv
// Measures the period of a one-hot tick stream, decodes it to the divider select code and tracks lock.
// Optional CLK_RATIO_LOSS_CNT_EN adds an 8-bit saturating loss_count output.
module clk_ratio_detector #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [CNT_W-1:0] period,
    output logic [1:0]       sel,
    output logic             sel_valid,
    output logic             locked,
    output logic             meas_done,
    output logic             lost
`ifdef CLK_RATIO_LOSS_CNT_EN
    ,
    output logic [7:0]       loss_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, MEASURE, TRACK, LOCKED} state_t;

    state_t           state_reg;
    logic             din_q_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] period_reg;
    logic [3:0]       match_cnt_reg;
    logic [1:0]       sel_reg;
    logic             sel_valid_reg;
    logic             locked_reg;
    logic             meas_done_reg;
    logic             lost_reg;

    logic             edge_det;
    logic             timeout;
    logic             legal;
    logic             same_period;
    logic             lost_set;
    logic [1:0]       sel_dec;
    logic [3:0]       match_inc;

    assign edge_det    = din & ~din_q_reg;
    assign timeout     = (cnt_reg == CNT_MAX) && !edge_det;
    assign same_period = (cnt_reg == period_reg);
    assign match_inc   = (match_cnt_reg >= LOCK_N) ? LOCK_N : match_cnt_reg + 4'd1;
    assign lost_set    = (state_reg == LOCKED) && ((edge_det && !same_period) || timeout);

    // The measured period is the counter value at the edge; map it to the divider select code.
    always_comb begin
        legal   = 1'b1;
        sel_dec = 2'b00;
        case (cnt_reg)
            CNT_W'(2): sel_dec = 2'b01;
            CNT_W'(3): sel_dec = 2'b00;
            CNT_W'(4): sel_dec = 2'b10;
            CNT_W'(8): sel_dec = 2'b11;
            default:   legal   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            din_q_reg     <= 1'b1;
            cnt_reg       <= '0;
            period_reg    <= '0;
            match_cnt_reg <= 4'd0;
            sel_reg       <= 2'b00;
            sel_valid_reg <= 1'b0;
            locked_reg    <= 1'b0;
            meas_done_reg <= 1'b0;
            lost_reg      <= 1'b0;
        end else begin
            din_q_reg     <= din;
            meas_done_reg <= 1'b0;
            lost_reg      <= lost_set;

            if (edge_det)
                cnt_reg <= CNT_W'(1);
            else if (cnt_reg != CNT_MAX)
                cnt_reg <= cnt_reg + 1'b1;

            if (edge_det && state_reg != IDLE) begin
                period_reg    <= cnt_reg;
                sel_reg       <= sel_dec;
                sel_valid_reg <= legal;
                meas_done_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (edge_det)
                        state_reg <= MEASURE;
                end
                MEASURE: begin
                    if (edge_det) begin
                        if (legal) begin
                            match_cnt_reg <= 4'd1;
                            if (LOCK_N == 4'd1) begin
                                state_reg  <= LOCKED;
                                locked_reg <= 1'b1;
                            end else begin
                                state_reg <= TRACK;
                            end
                        end
                    end else if (timeout) begin
                        state_reg     <= IDLE;
                        match_cnt_reg <= 4'd0;
                    end
                end
                TRACK: begin
                    if (edge_det) begin
                        if (!legal) begin
                            state_reg     <= MEASURE;
                            match_cnt_reg <= 4'd0;
                        end else if (same_period) begin
                            match_cnt_reg <= match_inc;
                            if (match_inc == LOCK_N) begin
                                state_reg  <= LOCKED;
                                locked_reg <= 1'b1;
                            end
                        end else begin
                            match_cnt_reg <= 4'd1;
                        end
                    end else if (timeout) begin
                        state_reg     <= IDLE;
                        match_cnt_reg <= 4'd0;
                    end
                end
                LOCKED: begin
                    if (edge_det && !same_period) begin
                        locked_reg <= 1'b0;
                        if (legal) begin
                            state_reg     <= TRACK;
                            match_cnt_reg <= 4'd1;
                        end else begin
                            state_reg     <= MEASURE;
                            match_cnt_reg <= 4'd0;
                        end
                    end else if (timeout) begin
                        locked_reg    <= 1'b0;
                        state_reg     <= IDLE;
                        match_cnt_reg <= 4'd0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef CLK_RATIO_LOSS_CNT_EN
    logic [7:0] loss_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst)
            loss_cnt_reg <= 8'd0;
        else if (lost_set && loss_cnt_reg != 8'hFF)
            loss_cnt_reg <= loss_cnt_reg + 8'd1;
    end

    assign loss_count = loss_cnt_reg;
`endif

    assign period    = period_reg;
    assign sel       = sel_reg;
    assign sel_valid = sel_valid_reg;
    assign locked    = locked_reg;
    assign meas_done = meas_done_reg;
    assign lost      = lost_reg;

endmodule

// File: tb/tb_clk_ratio_detector.sv
// Scoreboard bench: an edge-timestamp model predicts every measurement/loss event; a monitor checks them.
module tb_clk_ratio_detector;

    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 3;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din = 1'b1;
    logic [CNT_W-1:0] period;
    logic [1:0]       sel;
    logic             sel_valid;
    logic             locked;
    logic             meas_done;
    logic             lost;
`ifdef CLK_RATIO_LOSS_CNT_EN
    logic [7:0]       loss_count;
`endif

    clk_ratio_detector #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .period    (period),
        .sel       (sel),
        .sel_valid (sel_valid),
        .locked    (locked),
        .meas_done (meas_done),
        .lost      (lost)
`ifdef CLK_RATIO_LOSS_CNT_EN
        ,
        .loss_count(loss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] per;
        logic [1:0] sl;
        logic       sv;
        logic       lk;
        logic       ls;
        logic       md;
        logic [7:0] lc;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  n_ev   = 0;

    // Reference model state: timestamps of edges rather than a counter.
    int cyc = 0;
    int last_ref = 0;
    bit m_prev = 1'b1;
    bit m_idle = 1'b1;
    bit m_locked = 1'b0;
    int m_run = 0;
    int m_period = 0;
    int m_loss = 0;

    function automatic bit is_legal(int p);
        return (p == 2) || (p == 3) || (p == 4) || (p == 8);
    endfunction

    function automatic logic [1:0] sel_of(int p);
        case (p)
            2:       return 2'b01;
            4:       return 2'b10;
            8:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit d);
        bit   ev_meas = 1'b0;
        bit   ev_lost = 1'b0;
        bit   e;
        int   el;
        ev_t  ev;
        if (r) begin
            m_prev = 1'b1; m_idle = 1'b1; m_locked = 1'b0;
            m_run = 0; m_period = 0; m_loss = 0;
            last_ref = cyc + 1;
        end else begin
            el = cyc - last_ref;
            if (el > MAXC) el = MAXC;
            e = d && !m_prev;
            m_prev = d;
            if (e) begin
                if (m_idle) begin
                    m_idle = 1'b0;
                    m_run = 0;
                end else begin
                    ev_meas = 1'b1;
                    if (m_locked) begin
                        if (el != m_period) begin
                            ev_lost = 1'b1;
                            m_locked = 1'b0;
                            m_run = is_legal(el) ? 1 : 0;
                        end
                    end else if (!is_legal(el)) begin
                        m_run = 0;
                    end else if (m_run > 0 && el == m_period) begin
                        m_run++;
                        if (m_run >= LOCK_CNT) m_locked = 1'b1;
                    end else if (m_run > 0) begin
                        m_run = 1;
                    end else begin
                        m_run = 1;
                        if (LOCK_CNT == 1) m_locked = 1'b1;
                    end
                    m_period = el;
                end
                last_ref = cyc;
            end else if (!m_idle && el == MAXC) begin
                if (m_locked) ev_lost = 1'b1;
                m_idle = 1'b1; m_locked = 1'b0; m_run = 0;
            end
            if (ev_lost && m_loss < 255) m_loss++;
            if (ev_meas || ev_lost) begin
                ev.per = 8'(m_period);
                ev.sl  = sel_of(m_period);
                ev.sv  = is_legal(m_period);
                ev.lk  = m_locked;
                ev.ls  = ev_lost;
                ev.md  = ev_meas;
`ifdef CLK_RATIO_LOSS_CNT_EN
                ev.lc  = 8'(m_loss);
`else
                ev.lc  = 8'd0;
`endif
                exp_q.push_back(ev);
            end
        end
    endtask

    task automatic step(input bit r, input bit d);
        @(negedge clk);
        rst = r;
        din = d;
        model_step(r, d);
        cyc++;
    endtask

    task automatic gen(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b1);
            repeat (p - 1) step(1'b0, 1'b0);
        end
    endtask

    task automatic check_reset(input string tag);
        logic [7:0] lc;
        @(posedge clk);
        #2;
`ifdef CLK_RATIO_LOSS_CNT_EN
        lc = loss_count;
`else
        lc = 8'd0;
`endif
        checks++;
        if (period !== '0 || sel !== 2'b00 || sel_valid !== 1'b0 || locked !== 1'b0 ||
            meas_done !== 1'b0 || lost !== 1'b0 || lc !== 8'd0) begin
            errors++;
            $display("FAIL %s: got period=%0d sel=%b sv=%b lk=%b md=%b lost=%b lc=%0d, want all zero",
                     tag, period, sel, sel_valid, locked, meas_done, lost, lc);
        end else begin
            $display("reset %s: outputs at reset values", tag);
        end
    endtask

    // Monitor: every cycle where the DUT flags a measurement or loss is a transaction.
    initial begin
        ev_t act;
        ev_t exp;
        forever begin
            @(posedge clk);
            #2;
            if (meas_done === 1'b1 || lost === 1'b1) begin
                act.per = period; act.sl = sel; act.sv = sel_valid;
                act.lk = locked; act.ls = lost; act.md = meas_done;
`ifdef CLK_RATIO_LOSS_CNT_EN
                act.lc = loss_count;
`else
                act.lc = 8'd0;
`endif
                checks++;
                n_ev++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got per=%0d sel=%b sv=%b lk=%b lost=%b md=%b lc=%0d, want no event",
                             act.per, act.sl, act.sv, act.lk, act.ls, act.md, act.lc);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL event%0d: got per=%0d sel=%b sv=%b lk=%b lost=%b md=%b lc=%0d, want per=%0d sel=%b sv=%b lk=%b lost=%b md=%b lc=%0d",
                                 n_ev, act.per, act.sl, act.sv, act.lk, act.ls, act.md, act.lc,
                                 exp.per, exp.sl, exp.sv, exp.lk, exp.ls, exp.md, exp.lc);
                    end else begin
                        $display("ev%0d t=%0t per=%0d sel=%b sv=%b lk=%b lost=%b lc=%0d",
                                 n_ev, $time, act.per, act.sl, act.sv, act.lk, act.ls, act.lc);
                    end
                end
            end
        end
    end

    initial begin
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check_reset("initial");

        gen(2, 8);                 // lock at /2
        gen(8, 6);                 // /8 relock
        gen(4, 6);                 // lock at /4
        gen(3, 6);                 // switch to /3, relock
        repeat (260) step(1'b0, 1'b0);   // timeout while locked
        gen(3, 6);                 // relock from idle
        gen(255, 1);               // edge coincides with saturation: illegal period
        gen(3, 5);
        gen(5, 7);                 // illegal ratio, never locks

        gen(2, 6);                 // locked at /2, then reset mid-stream with din high
        step(1'b1, 1'b1);
        check_reset("mid_op");
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        gen(2, 6);
        gen(4, 5);                 // /2 -> /4 loss

        for (int s = 0; s < 25; s++) begin
            int sel_r;
            int p;
            sel_r = $urandom_range(0, 6);
            case (sel_r)
                0: p = 2;
                1: p = 3;
                2: p = 4;
                3: p = 8;
                default: p = $urandom_range(2, 12);
            endcase
            gen(p, $urandom_range(1, 6));
        end

        repeat (5) step(1'b0, 1'b0);
        @(posedge clk);
        #3;
        while (exp_q.size() > 0) begin
            ev_t m;
            m = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got none, want per=%0d lk=%b lost=%b md=%b", m.per, m.lk, m.ls, m.md);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
